// File: rtl/key_schedule_seq.sv
// Sequential AES key expansion producing one 32-bit schedule word per clock.
// States: IDLE waits for start | EXPAND writes one word per cycle | DONE keys readable.

module s_box (
  input  logic [7:0] byte_in,
  output logic [7:0] s_byte_out
);
  localparam logic [0:15][127:0] SBOX_ROWS = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [127:0] w_row;

  // Column c sits at bits [8*(15-c) +: 8]; ~c equals 15-c for a 4-bit column.
  always_comb begin
    w_row      = SBOX_ROWS[byte_in[7:4]];
    s_byte_out = w_row[{~byte_in[3:0], 3'b000} +: 8];
  end
endmodule

module key_schedule_seq #(
  parameter int KEY_WIDTH  = 128,
  parameter int DATA_WIDTH = 128,
  parameter int BYTE       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KEY_WIDTH-1:0]  key_in,
  output logic                  busy,
  output logic                  keys_valid,
  input  logic [3:0]            rk_idx,
  output logic [DATA_WIDTH-1:0] round_key
);
  localparam int NK = KEY_WIDTH / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK6     = 6'(NK);
  localparam logic [5:0] NW6     = 6'(NW);
  localparam logic [3:0] NR4     = 4'(NR);
  localparam logic [2:0] KC_LAST = 3'(NK - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_w [NW];
  logic [5:0]  r_i;
  logic [2:0]  r_kcnt;
  logic [7:0]  r_rcon;

  logic        w_load, w_write;
  logic [31:0] w_prev, w_back, w_rot, w_sub_in, w_sub_out, w_temp, w_new;
  logic [7:0]  w_rcon_nxt;
  logic [5:0]  w_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (r_i < NW6) w_write     = 1'b1;
        else           w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy       = (r_state == S_EXPAND);
  assign keys_valid = (r_state == S_DONE);

  // r_kcnt tracks i mod Nk so no divider is needed for the 192-bit case.
  always_comb begin
    w_prev   = r_w[r_i - 6'd1];
    w_back   = r_w[r_i - NK6];
    w_rot    = {w_prev[7:0], w_prev[31:24], w_prev[23:16], w_prev[15:8]};
    w_sub_in = (r_kcnt == 3'd0) ? w_rot : w_prev;
    if (r_kcnt == 3'd0)
      w_temp = w_sub_out ^ {24'h0, r_rcon};
    else if (NK == 8 && r_kcnt == 3'd4)
      w_temp = w_sub_out;
    else
      w_temp = w_prev;
    w_new      = w_back ^ w_temp;
    w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    s_box u_s_box (
      .byte_in   (w_sub_in[BYTE*g +: BYTE]),
      .s_byte_out(w_sub_out[BYTE*g +: BYTE])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i    <= 6'd0;
      r_kcnt <= 3'd0;
      r_rcon <= 8'h01;
      for (int j = 0; j < NW; j++) r_w[j] <= 32'h0;
    end else if (w_load) begin
      for (int j = 0; j < NK; j++) r_w[j] <= key_in[32*j +: 32];
      r_i    <= NK6;
      r_kcnt <= 3'd0;
      r_rcon <= 8'h01;
    end else if (w_write) begin
      r_w[r_i] <= w_new;
      r_i      <= r_i + 6'd1;
      r_kcnt   <= (r_kcnt == KC_LAST) ? 3'd0 : r_kcnt + 3'd1;
      if (r_kcnt == 3'd0) r_rcon <= w_rcon_nxt;
    end
  end

  always_comb begin
    round_key = '0;
    w_base    = {rk_idx, 2'b00};
    if (keys_valid && rk_idx <= NR4)
      round_key = {r_w[w_base + 6'd3], r_w[w_base + 6'd2], r_w[w_base + 6'd1], r_w[w_base]};
  end
endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: three key sizes, scoreboard of round keys from an
// independent FIPS-order model using an arithmetic (GF inverse) S-box.

module tb_key_schedule_seq;
  logic         clk;
  logic         rst_n;
  logic [2:0]   start;
  logic [2:0]   busy;
  logic [2:0]   kv;
  logic [3:0]   rk_idx;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [127:0] rk_out [3];

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q [$];

  key_schedule_seq #(.KEY_WIDTH(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .key_in(key128),
    .busy(busy[0]), .keys_valid(kv[0]), .rk_idx(rk_idx), .round_key(rk_out[0]));
  key_schedule_seq #(.KEY_WIDTH(192)) dut192 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .key_in(key192),
    .busy(busy[1]), .keys_valid(kv[1]), .rk_idx(rk_idx), .round_key(rk_out[1]));
  key_schedule_seq #(.KEY_WIDTH(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .key_in(key256),
    .busy(busy[2]), .keys_valid(kv[2]), .rk_idx(rk_idx), .round_key(rk_out[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] p;
    p = 8'h01;
    for (int k = 0; k < 254; k++) p = gmul(p, x);
    return p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw_m(input logic [31:0] w);
    return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
  endfunction

  // Round key in DUT layout from four FIPS-order words.
  function automatic logic [127:0] fips_rk(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3);
    return {bswap(w3), bswap(w2), bswap(w1), bswap(w0)};
  endfunction

  // Key k holds FIPS word j at [255-32j -: 32].
  task automatic model_push(input int nk, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr, nw;
    nr = nk + 6; nw = 4 * (nr + 1); rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw_m(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      exp_q.push_back(fips_rk(w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]));
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_key(input int d, input logic [255:0] k);
    logic [255:0] dk;
    int nk;
    nk = 4 + 2 * d;
    dk = '0;
    for (int j = 0; j < nk; j++) dk[32*j +: 32] = bswap(k[255-32*j -: 32]);
    case (d)
      0:       key128 = dk[127:0];
      1:       key192 = dk[191:0];
      default: key256 = dk;
    endcase
  endtask

  // Drives start through one rising edge; returns #1 after that edge.
  task automatic do_start(input int d, input logic [255:0] k, input bit push);
    set_key(d, k);
    if (push) model_push(4 + 2 * d, k);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, input int n0, input int exp_lat, input string tag);
    int n;
    n = n0;
    while (!kv[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 128'(n), 128'(exp_lat));
  endtask

  task automatic drain(input int d, input string tag);
    logic [127:0] e;
    for (int r = 0; r <= 6 + 4 + 2 * d; r++) begin
      @(negedge clk);
      rk_idx = 4'(r);
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL %s_empty observed=none expected=entry", tag);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_rk%0d", tag, r), rk_out[d], e);
      end
    end
  endtask

  task automatic read_rk(input int d, input int r, input logic [127:0] exp, input string tag);
    @(negedge clk);
    rk_idx = 4'(r);
    #1;
    check(tag, rk_out[d], exp);
  endtask

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KB = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  initial begin
    rst_n = 1'b0; start = 3'b000; rk_idx = 4'd0;
    key128 = '0; key192 = '0; key256 = '0;
    #2;
    check("reset_busy", 128'(busy), 128'h0);
    check("reset_valid", 128'(kv), 128'h0);
    check("reset_rk", rk_out[0], 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // AES-128 FIPS vector; key_in scrambled after start must not matter
    do_start(0, K128, 1'b1);
    key128 = {$urandom, $urandom, $urandom, $urandom};
    check("busy_128", 128'(busy[0]), 128'h1);
    wait_valid(0, 0, 41, "lat_128");
    check("busy_done_128", 128'(busy[0]), 128'h0);
    drain(0, "aes128");
    read_rk(0, 10, fips_rk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6), "fips128_rk10");
    read_rk(0, 0, fips_rk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c), "fips128_rk0");
    read_rk(0, 11, 128'h0, "range128_rk11");
    read_rk(0, 15, 128'h0, "range128_rk15");

    // AES-192
    @(posedge clk); #1;
    do_start(1, K192, 1'b1);
    wait_valid(1, 0, 47, "lat_192");
    drain(1, "aes192");
    read_rk(1, 12, fips_rk(32'he98ba06f, 32'h448c773c, 32'h8ecc7204, 32'h01002202), "fips192_rk12");
    read_rk(1, 13, 128'h0, "range192_rk13");

    // AES-256
    @(posedge clk); #1;
    do_start(2, K256, 1'b1);
    wait_valid(2, 0, 53, "lat_256");
    drain(2, "aes256");
    read_rk(2, 14, fips_rk(32'hfe4890d1, 32'he6188d0b, 32'h046df344, 32'h706c631e), "fips256_rk14");
    read_rk(2, 15, 128'h0, "range256_rk15");

    // start while busy is ignored
    @(posedge clk); #1;
    do_start(0, KB, 1'b1);
    repeat (9) begin @(posedge clk); #1; end
    set_key(0, K128);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    check("busy_after_ignored_start", 128'(busy[0]), 128'h1);
    wait_valid(0, 10, 41, "lat_ignored_start");
    drain(0, "ignored_start");

    // restart from DONE drops keys_valid next cycle
    @(posedge clk); #1;
    do_start(0, K128, 1'b1);
    check("restart_valid_drop", 128'(kv[0]), 128'h0);
    check("restart_busy", 128'(busy[0]), 128'h1);
    wait_valid(0, 0, 41, "lat_restart");
    drain(0, "restart");

    // reset mid-expansion aborts; a fresh start is needed
    @(posedge clk); #1;
    do_start(0, KB, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(busy[0]), 128'h0);
    check("abort_valid", 128'(kv[0]), 128'h0);
    check("abort_rk", rk_out[0], 128'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("post_reset_idle_busy", 128'(busy[0]), 128'h0);
    check("post_reset_idle_valid", 128'(kv[0]), 128'h0);
    do_start(0, KB, 1'b1);
    wait_valid(0, 0, 41, "lat_after_abort");
    drain(0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_schedule_seq.md
KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n; no other clock or reset SHALL exist.
REQ-002 Parameter KEY_WIDTH, default 128, SHALL set the cipher key width; legal values are 128, 192 and 256.
REQ-003 Parameter DATA_WIDTH, default 128, SHALL set the round-key width; only 128 is legal.
REQ-004 Parameter BYTE, default 8, SHALL set the byte width used for S-box lanes.
REQ-005 Port clk SHALL be input, 1 bit, the rising-edge clock.
REQ-006 Port rst_n SHALL be input, 1 bit, the asynchronous active-low reset.
REQ-007 Port start SHALL be input, 1 bit, a single-cycle request to expand key_in.
REQ-008 Port key_in SHALL be input, KEY_WIDTH bits, the cipher key: word j at [32j+31:32j], and within each word byte 0 at [7:0].
REQ-009 Port busy SHALL be output, 1 bit, high while expansion is in progress.
REQ-010 Port keys_valid SHALL be output, 1 bit, high when all round keys are stored and readable.
REQ-011 Port rk_idx SHALL be input, 4 bits, the round-key index to read.
REQ-012 Port round_key SHALL be output, DATA_WIDTH bits, the round key selected by rk_idx.

Function
REQ-013 Derived values: Nk = KEY_WIDTH/32, Nr = Nk+6, and total words W = 4*(Nr+1), i.e. 44, 52 or 60.
REQ-014 Word storage SHALL be a W x 32-bit register array written by the block only.
REQ-015 FSM states SHALL be IDLE, EXPAND and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL load key words 0..Nk-1 into storage, clear the word counter i to Nk, reset Rcon to 0x01, set busy=1 and keys_valid=0, and enter EXPAND.
REQ-017 In EXPAND, exactly one word w[i] SHALL be written per cycle, then i increments; after the write of w[W-1] the FSM SHALL enter DONE with busy=0 and keys_valid=1 in the following cycle.
REQ-018 Start-to-keys_valid latency SHALL be W-Nk+1 cycles: 41, 47 or 53.
REQ-019 Word rule, where temp = w[i-1]:
  - i mod Nk == 0: temp = SubWord(RotWord(temp)) XOR Rcon; RotWord gives {b0,b3,b2,b1} in [31:0] byte order; Rcon is XORed into [7:0].
  - Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - Then w[i] = w[i-Nk] XOR temp.
REQ-020 Rcon SHALL advance by xtime (left-shift, XOR 0x1B on carry) after each i mod Nk == 0 word.
REQ-021 SubWord SHALL use exactly four instances of the existing s_box module (byte_in, s_byte_out), shared by all words.
REQ-022 round_key SHALL be combinational: {w[4r+3], w[4r+2], w[4r+1], w[4r]} for r = rk_idx, with w[4r] at [31:0].
REQ-023 round_key SHALL be all-zero when keys_valid=0 or rk_idx > Nr.
REQ-024 start while busy=1 SHALL be ignored; expansion continues unaffected.
REQ-025 start in DONE SHALL restart expansion, and keys_valid SHALL drop in the next cycle.
REQ-026 key_in SHALL be sampled only in the start cycle; later changes SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, busy=0, keys_valid=0, i=0, Rcon=0x01, and storage to zero, so round_key=0.
REQ-028 Reset asserted mid-EXPAND SHALL abort expansion; after release, the block SHALL require a new start.

Verification
REQ-029 KEY_WIDTH=128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c (FIPS-197 byte order) -> keys_valid 41 cycles after start; rk_idx=10 gives words d014f9a8 c9ee2589 e13f0cc8 b6630ca6; rk_idx=0 gives the key.
REQ-030 KEY_WIDTH=192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> latency 47 cycles; rk_idx=12 gives e98ba06f 448c773c 8ecc7204 01002202.
REQ-031 KEY_WIDTH=256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d98 10a3 0914dff4 -> latency 53 cycles; rk_idx=14 gives fe4890d1 e6188d0b 046df344 706c631e.
REQ-032 Pulse start again at cycle 10 of an AES-128 run with a different key -> ignored; final keys match the first key.
REQ-033 Assert rst_n=0 at cycle 20 of a run -> busy=0 and round_key=0 immediately; a fresh start then completes in 41 cycles with correct keys.
REQ-034 After keys_valid, set rk_idx=15 (AES-128) -> round_key=0; rk_idx=11 with KEY_WIDTH=128 -> round_key=0.
